// File: rtl/ema_filter_mc.sv
// Multichannel exponential moving average filter with a shared datapath.
// Per-channel state lives in a small RAM; a walker zeroes it on reset/clear.
module ema_filter_mc #(
  parameter int NCH   = 4,
  parameter int IW    = 20,
  parameter int LGMAX = 12,
  parameter int OW    = IW + 1,
  parameter int CW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CW-1:0]        s_chan,
  input  logic signed [IW-1:0] s_in,
  input  logic [3:0]           lgalpha,
  output logic                 m_valid,
  output logic [CW-1:0]        m_chan,
  output logic signed [OW-1:0] s_out
);

  localparam int AW = IW + LGMAX + 1;
  localparam logic [3:0] LGM = 4'(LGMAX);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] caddr_q, caddr_d;

  logic signed [AW-1:0] acc_mem [NCH];
  logic [NCH-1:0]       pr_mem;

  logic                 s1_v_q, s2_v_q;
  logic [CW-1:0]        s1_ch_q, s2_ch_q;
  logic signed [IW-1:0] s1_x_q, s2_x_q;
  logic [3:0]           s1_l_q, s2_l_q;
  logic signed [AW-1:0] s2_acc_q;
  logic                 s2_pr_q;

  logic                 m_valid_q;
  logic [CW-1:0]        m_chan_q;
  logic signed [OW-1:0] s_out_q;

  logic                 take;
  logic [3:0]           l_cl;
  logic                 fwd;
  logic signed [AW-1:0] rd_acc;
  logic                 rd_pr;
  logic signed [AW-1:0] x_sc;
  logic signed [AW-1:0] diff;
  logic signed [AW-1:0] step;
  logic signed [AW-1:0] acc_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    caddr_d = caddr_q;
    if (clear) begin
      state_d = CLEAR;
      caddr_d = '0;
    end else if (state_q == CLEAR) begin
      if (caddr_q == CW'(NCH - 1)) begin
        state_d = IDLE;
      end else begin
        caddr_d = caddr_q + CW'(1);
      end
    end
  end

  assign s_ready = (state_q == IDLE) && !clear;
  assign take    = s_valid && s_ready && (32'(s_chan) < NCH);
  assign l_cl    = (lgalpha > LGM) ? LGM : lgalpha;

  // Back-to-back hits on one channel take the in-flight result, not RAM.
  assign fwd    = s2_v_q && (s2_ch_q == s1_ch_q);
  assign rd_acc = fwd ? acc_new : acc_mem[s1_ch_q];
  assign rd_pr  = fwd ? 1'b1 : pr_mem[s1_ch_q];

  assign x_sc = {s2_x_q[IW-1], s2_x_q, {LGMAX{1'b0}}};

  always_comb begin
    diff    = x_sc - s2_acc_q;
    step    = diff >>> s2_l_q;
    acc_new = s2_acc_q + step;
    if (!s2_pr_q || s2_l_q == 4'd0) begin
      acc_new = x_sc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= take;
      s2_v_q <= s1_v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      s1_ch_q <= s_chan;
      s1_x_q  <= s_in;
      s1_l_q  <= l_cl;
    end
    s2_ch_q  <= s1_ch_q;
    s2_x_q   <= s1_x_q;
    s2_l_q   <= s1_l_q;
    s2_acc_q <= rd_acc;
    s2_pr_q  <= rd_pr;
  end

  // The clear walk owns the single write port while it runs.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      acc_mem[caddr_q] <= '0;
      pr_mem[caddr_q]  <= 1'b0;
    end else if (s2_v_q) begin
      acc_mem[s2_ch_q] <= acc_new;
      pr_mem[s2_ch_q]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_chan_q  <= '0;
      s_out_q   <= '0;
    end else begin
      m_valid_q <= s2_v_q;
      if (s2_v_q) begin
        m_chan_q <= s2_ch_q;
        s_out_q  <= OW'(acc_new >>> LGMAX);
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_chan  = m_chan_q;
  assign s_out   = s_out_q;

endmodule

// File: tb/tb_ema_filter_mc.sv
// Scoreboard bench for ema_filter_mc: directed samples push expectations,
// a negedge monitor pops and checks tag, value and latency.
module tb_ema_filter_mc;

  localparam int NCH = 4;
  localparam int IW  = 20;
  localparam int OW  = 21;
  localparam int CW  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [CW-1:0]        s_chan = '0;
  logic signed [IW-1:0] s_in = '0;
  logic [3:0]           lgalpha = '0;
  logic                 m_valid;
  logic [CW-1:0]        m_chan;
  logic signed [OW-1:0] s_out;

  ema_filter_mc #(.NCH(NCH), .IW(IW), .LGMAX(12)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_chan(s_chan), .s_in(s_in), .lgalpha(lgalpha),
    .m_valid(m_valid), .m_chan(m_chan), .s_out(s_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int val;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (m_valid) begin
      ntests++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_out: got ch=%0d out=%0d cyc=%0d, required no output",
                 m_chan, s_out, cyc);
      end else begin
        e = q.pop_front();
        if (int'(m_chan) != e.ch || int'(s_out) != e.val || cyc != e.due) begin
          nfail++;
          $display("FAIL out_ch%0d: got ch=%0d out=%0d cyc=%0d, required ch=%0d out=%0d cyc=%0d",
                   e.ch, m_chan, s_out, cyc, e.ch, e.val, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int req);
    ntests++;
    if (got != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic send(input int ch, input int x, input int l, input int ev);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_chan  = ch[CW-1:0];
    s_in    = x[IW-1:0];
    lgalpha = l[3:0];
    #1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      ntests++;
      nfail++;
      $display("FAIL send_timeout: got s_ready=0, required 1 on ch %0d", ch);
    end else begin
      q.push_back('{ch, ev, cyc + 3});
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic do_clear(output int cnt);
    @(negedge clk);
    clear = 1'b1;
    #1;
    cnt = s_ready ? 0 : 1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    #1;
    while (!s_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   vals[4];
    longint acc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", int'({m_valid, m_chan, s_out}), 0);
    rst = 1'b0;
    #1;
    cnt = 0;
    while (!s_ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("rst_ready_low", cnt, 4);

    send(0, 1000, 4, 1000);
    send(0, 0, 4, 937);

    acc = 64'sd4096 * 64'sd4096;
    send(2, 4096, 2, 4096);
    for (int i = 0; i < 20; i++) begin
      acc = acc + ((64'sd0 - acc) >>> 2);
      send(2, 0, 2, int'(acc >>> 12));
    end

    acc = 64'sd4096 * 64'sd4096;
    send(3, 4096, 2, 4096);
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge clk);
      acc = acc + ((64'sd0 - acc) >>> 2);
      send(3, 0, 2, int'(acc >>> 12));
    end

    do_clear(cnt);
    chk("clear_idle_ready_low", cnt, 5);

    vals = '{100, -100, 32767, -524288};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        send(c, vals[c], 12, vals[c]);
      end
    end

    send(1, 0, 0, 0);
    send(1, 5000, 15, 1);
    send(1, -7, 0, -7);

    send(0, 100, 12, 100);
    send(3, -524288, 12, -524288);
    do_clear(cnt);
    chk("clear_mid_ready_low", cnt, 5);
    send(1, 1234, 5, 1234);
    send(2, -55, 3, -55);
    send(2, -55, 3, -55);

    repeat (6) @(negedge clk);
    chk("drain_queue", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
